skylark_dmem_ctrl: RTL and testbench

SKYLARK_DMEM_CTRL -- requirements
Module: skylark_dmem_ctrl

---
 rtl/skylark_mem_pkg.sv | 37 +++
 rtl/skylark_tx_fifo.sv | 63 ++++++
 rtl/skylark_dmem_ctrl.sv | 121 ++++++++++++
 tb/tb_skylark_dmem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skylark_mem_pkg.sv
// Shared address map, region decode and STATUS layout for the skylark
// data-memory controller.
package skylark_mem_pkg;

  localparam logic [31:0] ADDR_GPIO   = 32'h8000_0000;
  localparam logic [31:0] ADDR_TX     = 32'h8000_0004;
  localparam logic [31:0] ADDR_CYCLES = 32'h8000_0008;

  // STATUS word: {16'b0, count[7:0], 5'b0, overflow, full, empty}
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 8;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_TX,
    REG_CYCLES,
    REG_NONE
  } region_e;

  // Misaligned addresses never hit a region, even if they fall inside RAM.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes);
    region_e r;
    r = REG_NONE;
    if (addr[1:0] == 2'b00) begin
      if (addr < ram_bytes)          r = REG_RAM;
      else if (addr == ADDR_GPIO)    r = REG_GPIO;
      else if (addr == ADDR_TX)      r = REG_TX;
      else if (addr == ADDR_CYCLES)  r = REG_CYCLES;
    end
    return r;
  endfunction

endpackage

// File: rtl/skylark_tx_fifo.sv
// Byte-wide transmit FIFO. Head byte is presented combinationally on dout;
// dout reads 0 whenever the FIFO is empty (including during reset).
// A push while full is accepted only when a pop happens on the same edge.
module skylark_tx_fifo #(
  parameter int TX_DEPTH = 4,
  localparam int PW = $clog2(TX_DEPTH),
  localparam int CW = $clog2(TX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(TX_DEPTH));
  assign count   = count_q;
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Storage is not reset; empty masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and count registers, cleared asynchronously to drop queued bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/skylark_dmem_ctrl.sv
// Data-memory controller for the skylark core: word RAM plus three MMIO
// registers (GPIO, TX FIFO data/status, free-running cycle counter).
// Loads are combinational; stores commit on the rising edge.
module skylark_dmem_ctrl
  import skylark_mem_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteW,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fault
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(TX_DEPTH + 1);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  region_e            region;
  logic [RAM_AW-1:0]  ram_idx;
  logic               st_ram, st_gpio, st_tx, st_bad;

  logic [31:0]        ram_q [RAM_WORDS];
  logic [7:0]         gpio_q, gpio_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               ovf_q, ovf_d;
  logic               fault_q, fault_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [31:0]        status;

  assign region  = decode_region(ALUResultW, RAM_BYTES);
  assign ram_idx = ALUResultW[RAM_AW+1:2];

  assign st_ram  = MemWriteW && (region == REG_RAM);
  assign st_gpio = MemWriteW && (region == REG_GPIO);
  assign st_tx   = MemWriteW && (region == REG_TX);
  assign st_bad  = MemWriteW && (region == REG_NONE);

  assign fifo_pop = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;

  skylark_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (st_tx),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register next-state: GPIO latch, cycle counter, sticky overflow, fault pulse.
  always_comb begin
    gpio_d   = gpio_q;
    cycles_d = cycles_q + 32'd1;
    ovf_d    = ovf_q;
    fault_d  = st_bad;
    if (st_gpio) gpio_d = WriteData[7:0];
    // A push to a full FIFO is only lost when nothing leaves on the same edge.
    if (st_tx && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (st_ram) ram_q[ram_idx] <= WriteData;
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q   <= '0;
      cycles_q <= '0;
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      gpio_q   <= gpio_d;
      cycles_q <= cycles_d;
      ovf_q    <= ovf_d;
      fault_q  <= fault_d;
    end
  end

  // Assemble the STATUS word from FIFO state.
  always_comb begin
    status                        = '0;
    status[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
    status[STAT_OVF_BIT]          = ovf_q;
    status[STAT_FULL_BIT]         = fifo_full;
    status[STAT_EMPTY_BIT]        = fifo_empty;
  end

  // Zero-latency load mux; unmapped and misaligned reads return 0.
  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM:    ReadData = ram_q[ram_idx];
      REG_GPIO:   ReadData = {24'b0, gpio_q};
      REG_TX:     ReadData = status;
      REG_CYCLES: ReadData = cycles_q;
      default:    ReadData = '0;
    endcase
  end

  assign gpio_out = gpio_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_skylark_dmem_ctrl.sv
// Scoreboard bench for skylark_dmem_ctrl. A reference model tracks memory,
// GPIO, the TX byte stream and counters; a negedge monitor compares outputs.
module tb_skylark_dmem_ctrl;

  localparam int          RAM_WORDS = 256;
  localparam int          TX_DEPTH  = 4;
  localparam logic [31:0] A_GPIO    = 32'h8000_0000;
  localparam logic [31:0] A_TX      = 32'h8000_0004;
  localparam logic [31:0] A_CYC     = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteW;
  logic [31:0] ALUResultW;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skylark_dmem_ctrl #(
    .RAM_WORDS (RAM_WORDS),
    .TX_DEPTH  (TX_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteW  (MemWriteW),
    .ALUResultW (ALUResultW),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .gpio_out   (gpio_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fault      (fault)
  );

  // Reference model state
  logic [31:0] m_mem [RAM_WORDS];
  logic [7:0]  m_gpio;
  int          m_cnt;
  logic        m_ovf;
  logic        m_fault;
  logic [31:0] m_ncyc;
  logic [31:0] cyc_base;
  logic [7:0]  exp_tx[$];
  bit          rd_chk_en;
  bit          m_pop;
  int          m_rg;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // 0 ram, 1 gpio, 2 tx, 3 cycles, 4 nothing
  function automatic int m_region(input logic [31:0] a);
    if (a % 4 != 0)            return 4;
    if (a < 4 * RAM_WORDS)     return 0;
    if (a == A_GPIO)           return 1;
    if (a == A_TX)             return 2;
    if (a == A_CYC)            return 3;
    return 4;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (m_region(a))
      0: return m_mem[int'(a / 4)];
      1: return {24'b0, m_gpio};
      2: return {16'b0, 8'(m_cnt), 5'b0, m_ovf, (m_cnt == TX_DEPTH), (m_cnt == 0)};
      3: return m_ncyc + cyc_base;
      default: return 32'h0;
    endcase
  endfunction

  // Model update on each edge from the inputs the core presented this cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gpio  = 8'h00;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_fault = 1'b0;
      m_ncyc  = 32'h0;
      exp_tx.delete();
    end else begin
      m_pop   = (m_cnt > 0) && tx_ready;
      m_rg    = m_region(ALUResultW);
      m_fault = MemWriteW && (m_rg == 4);
      if (MemWriteW) begin
        case (m_rg)
          0: m_mem[int'(ALUResultW / 4)] = WriteData;
          1: m_gpio = WriteData[7:0];
          2: begin
            if (m_cnt < TX_DEPTH || m_pop) begin
              exp_tx.push_back(WriteData[7:0]);
              m_cnt++;
            end else begin
              m_ovf = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (m_pop) m_cnt--;
      m_ncyc = m_ncyc + 32'd1;
    end
  end

  // Monitor: compares every output mid-cycle; pops the expected byte stream on handshakes.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
    end else begin
      chk("tx_valid", 32'(tx_valid), 32'(m_cnt > 0));
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e));
        end
      end
    end
    chk("fault", 32'(fault), 32'(m_fault));
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
    if (rd_chk_en && !reset) chk("ReadData", ReadData, m_read(ALUResultW));
  end

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWriteW  = we;
    ALUResultW = a;
    WriteData  = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
  endtask

  task automatic load(input logic [31:0] a);
    drive(1'b0, a, $urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      load(A_TX);
      tx_ready = 1'b1;
      if (m_cnt == 0) break;
    end
    @(negedge clk);
    chk("drain_tx_valid", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1, v2;
    MemWriteW  = 1'b0;
    ALUResultW = 32'h0;
    WriteData  = 32'h0;
    tx_ready   = 1'b0;
    cyc_base   = 32'h0;
    rd_chk_en  = 1'b0;
    reset      = 1'b1;
    #2;
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_gpio", 32'(gpio_out), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Bring RAM to a known zero state.
    for (int i = 0; i < RAM_WORDS; i++) store(32'(i * 4), 32'h0);
    load(32'h0);
    rd_chk_en = 1'b1;

    // Store then load on the next cycle; untouched word reads zero.
    store(32'h10, 32'hDEAD_BEEF);
    load(32'h10);
    @(negedge clk) chk("ld_after_st", ReadData, 32'hDEAD_BEEF);
    load(32'h14);
    @(negedge clk) chk("ld_unwritten", ReadData, 32'h0);

    // Full FIFO with simultaneous pop and push: no overflow, 0x55 goes last.
    tx_ready = 1'b0;
    for (int b = 8'h11; b <= 8'h14; b++) store(A_TX, 32'(b));
    load(A_TX);
    @(negedge clk) chk("status_full", ReadData, 32'h0000_0402);
    store(A_TX, 32'h55);
    tx_ready = 1'b1;
    load(A_TX);
    tx_ready = 1'b0;
    @(negedge clk) chk("status_push_pop_full", ReadData, 32'h0000_0402);
    drain();

    // Overflow: fifth byte lost, sticky flag set.
    tx_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h45; b++) store(A_TX, 32'(b));
    load(A_TX);
    @(negedge clk);
    chk("status_overflow", ReadData, 32'h0000_0406);
    chk("head_byte", 32'(tx_data), 32'h41);
    drain();
    load(A_TX);
    @(negedge clk) chk("overflow_sticky", ReadData, 32'h0000_0005);

    // Misaligned and unmapped stores: fault pulse, no side effects.
    store(32'h0, 32'h1234_5678);
    store(A_GPIO, 32'h3C);
    store(32'h2, 32'hFFFF_FFFF);
    load(32'h2);
    @(negedge clk);
    chk("fault_misaligned", 32'(fault), 32'h1);
    chk("ld_misaligned", ReadData, 32'h0);
    store(32'h4000_0000, 32'hFFFF_FFFF);
    load(32'h4000_0000);
    @(negedge clk);
    chk("fault_unmapped", 32'(fault), 32'h1);
    chk("ld_unmapped", ReadData, 32'h0);
    load(32'h0);
    @(negedge clk);
    chk("fault_clears", 32'(fault), 32'h0);
    chk("ram_untouched", ReadData, 32'h1234_5678);
    load(A_GPIO);
    @(negedge clk) chk("gpio_untouched", ReadData, 32'h3C);

    // GPIO write/readback, then reset mid-drain with 3 bytes queued.
    store(A_GPIO, 32'hA5);
    load(A_GPIO);
    @(negedge clk);
    chk("gpio_out_a5", 32'(gpio_out), 32'hA5);
    chk("gpio_readback", ReadData, 32'h0000_00A5);
    tx_ready = 1'b0;
    for (int b = 8'h61; b <= 8'h64; b++) store(A_TX, 32'(b));
    load(A_TX);
    tx_ready = 1'b1;
    @(posedge clk);
    #3;
    reset    = 1'b1;
    cyc_base = 32'h0;
    #1;
    chk("midrst_gpio", 32'(gpio_out), 32'h0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
    chk("midrst_status", ReadData, 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    tx_ready = 1'b0;

    // Cycle counter: 10-cycle delta, ignored write, wrap.
    load(A_CYC);
    @(negedge clk) v1 = ReadData;
    repeat (10) @(posedge clk);
    @(negedge clk) v2 = ReadData;
    chk("cycles_delta", v2 - v1, 32'd10);
    store(A_CYC, 32'h0000_1234);
    load(A_CYC);
    @(negedge clk) chk("cycles_write_no_fault", 32'(fault), 32'h0);
    @(posedge clk);
    #2;
    force dut.cycles_q = 32'hFFFF_FFFF;
    cyc_base = 32'hFFFF_FFFF - m_ncyc;
    #1;
    release dut.cycles_q;
    @(negedge clk) chk("cycles_forced", ReadData, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 chk("cycles_wrap", ReadData, 32'h0);

    // Randomized mix of loads/stores across all regions.
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      bit          we;
      case ($urandom_range(0, 7))
        0, 1:    a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
        2:       a = A_GPIO;
        3, 4:    a = A_TX;
        5:       a = A_CYC;
        6:       a = 32'($urandom_range(0, 4 * RAM_WORDS - 1)) | 32'h1;
        default: a = 32'h4000_0000 + (32'($urandom_range(0, 15)) << 2);
      endcase
      we = 1'($urandom_range(0, 1));
      drive(we, a, $urandom);
      tx_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
